// File: rtl/tcp_arb_pkg.sv
// Shared types and helpers for the TCP controller arbiters.
// No logic; pure declarations. No backpressure involvement.
package tcp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/tcp_rr_pick.sv
// Rotate-and-priority-encode: first set request at or above base, wrapping.
// Latency: combinational. Backpressure: none, pure function of inputs.
module tcp_rr_pick
    import tcp_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] base,
    input  logic          mode,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0]  start_v;
    logic [2*N-1:0] dbl;
    logic [IW:0]    sum;

    always_comb begin
        start_v = (mode == ARB_FIXED) ? '0 : base;
        // Doubling the vector makes the wrap-around scan a plain shift.
        dbl     = {req, req} >> start_v;
        sum     = '0;
        any     = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (dbl[i]) sum = {1'b0, start_v} + (IW + 1)'(i);
        end
        if (sum >= (IW + 1)'(N)) idx = IW'(sum - (IW + 1)'(N));
        else                     idx = sum[IW-1:0];
    end

endmodule

// File: rtl/tcp_unconf_mem_rr_arbiter.sv
// Grants one TCP controller access to unconfirmed memory (RR or fixed priority).
// Latency: req_i to gnt_o 2 cycles; exit to next grant 1 drop edge + 2 cycles.
// Backpressure: wr_allow_i=0 holds off new grants only; active grants run on.
module tcp_unconf_mem_rr_arbiter
    import tcp_arb_pkg::*;
#(
    parameter  int DEVICE_NUM = 4,
    parameter  int HOLD_W     = 16,
    parameter  int MAX_HOLD   = 1024,
    localparam int IDXW       = clog2(DEVICE_NUM)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_allow_i,
    input  logic                  mode_i,
    input  logic [DEVICE_NUM-1:0] req_i,
    input  logic                  done_i,
    output logic [DEVICE_NUM-1:0] gnt_o,
    output logic                  gnt_vld_o,
    output logic [IDXW-1:0]       gnt_idx_o,
    output logic [IDXW-1:0]       last_idx_o,
    output logic                  timeout_o,
    output logic                  busy_o
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_e            state_q, state_d;
    logic [DEVICE_NUM-1:0] req_r_q;
    logic [DEVICE_NUM-1:0] gnt_q, gnt_d;
    logic                  gnt_vld_q, gnt_vld_d;
    logic [IDXW-1:0]       gnt_idx_q, gnt_idx_d;
    logic [IDXW-1:0]       last_idx_q, last_idx_d;
    logic                  timeout_q, timeout_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;

    logic [IDXW-1:0] rr_base;
    logic [IDXW-1:0] pick_idx;
    logic            pick_any;
    logic            withdrawn;
    logic            wd_hit;

    assign rr_base = (last_idx_q == IDXW'(DEVICE_NUM - 1)) ? '0 : last_idx_q + IDXW'(1);

    tcp_rr_pick #(
        .N  (DEVICE_NUM),
        .IW (IDXW)
    ) u_pick (
        .req  (req_r_q),
        .base (rr_base),
        .mode (mode_i),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // gnt_q is one-hot on the owner, so this tests the owner's registered request.
    assign withdrawn = ~|(req_r_q & gnt_q);
    assign wd_hit    = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        gnt_vld_d  = gnt_vld_q;
        gnt_idx_d  = gnt_idx_q;
        last_idx_d = last_idx_q;
        timeout_d  = 1'b0;
        hold_d     = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_allow_i && pick_any) begin
                    state_d   = ST_GRANT;
                    gnt_d     = DEVICE_NUM'(1) << pick_idx;
                    gnt_vld_d = 1'b1;
                    gnt_idx_d = pick_idx;
                    hold_d    = '0;
                end
            end
            ST_GRANT: begin
                if (hold_q != '1) hold_d = hold_q + HOLD_W'(1);
                if (done_i || withdrawn || wd_hit) begin
                    state_d   = ST_RELEASE;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    timeout_d = wd_hit && !done_i && !withdrawn;
                end
            end
            ST_RELEASE: begin
                last_idx_d = gnt_idx_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_r_q    <= '0;
            gnt_q      <= '0;
            gnt_vld_q  <= 1'b0;
            gnt_idx_q  <= '0;
            last_idx_q <= IDXW'(DEVICE_NUM - 1);
            timeout_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            req_r_q    <= req_i;
            gnt_q      <= gnt_d;
            gnt_vld_q  <= gnt_vld_d;
            gnt_idx_q  <= gnt_idx_d;
            last_idx_q <= last_idx_d;
            timeout_q  <= timeout_d;
            hold_q     <= hold_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign gnt_vld_o  = gnt_vld_q;
    assign gnt_idx_o  = gnt_idx_q;
    assign last_idx_o = last_idx_q;
    assign timeout_o  = timeout_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcp_unconf_mem_rr_arbiter.sv
// Bench for tcp_unconf_mem_rr_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level owner/cooldown model.
module tb_tcp_unconf_mem_rr_arbiter;

    localparam int N  = 4;
    localparam int MH = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_allow_i;
    logic         mode_i;
    logic [N-1:0] req_i;
    logic         done_i;
    logic [N-1:0] gnt_o;
    logic         gnt_vld_o;
    logic [1:0]   gnt_idx_o;
    logic [1:0]   last_idx_o;
    logic         timeout_o;
    logic         busy_o;

    always #5 clk = ~clk;

    tcp_unconf_mem_rr_arbiter #(
        .DEVICE_NUM (N),
        .HOLD_W     (16),
        .MAX_HOLD   (MH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_allow_i (wr_allow_i),
        .mode_i     (mode_i),
        .req_i      (req_i),
        .done_i     (done_i),
        .gnt_o      (gnt_o),
        .gnt_vld_o  (gnt_vld_o),
        .gnt_idx_o  (gnt_idx_o),
        .last_idx_o (last_idx_o),
        .timeout_o  (timeout_o),
        .busy_o     (busy_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: who owns the memory, how long, and whether a cooldown cycle is pending.
    int m_req_r, m_owner, m_hold, m_cool, m_last, m_idx, m_to;

    task automatic model_reset();
        m_req_r = 0; m_owner = -1; m_hold = 0; m_cool = 0;
        m_last  = N - 1; m_idx = 0; m_to = 0;
    endtask

    task automatic model_step();
        int  nreq, cand, win;
        bit  d, wdr, t;
        nreq = int'(req_i);
        m_to = 0;
        if (m_owner >= 0) begin
            d   = done_i;
            wdr = ((m_req_r >> m_owner) & 1) == 0;
            t   = (m_hold == MH - 1);
            if (d || wdr || t) begin
                m_to    = (t && !d && !wdr) ? 1 : 0;
                m_owner = -1;
                m_cool  = 1;
            end else begin
                m_hold++;
            end
        end else if (m_cool != 0) begin
            m_cool = 0;
            m_last = m_idx;
        end else if (wr_allow_i && m_req_r != 0) begin
            win = -1;
            for (int k = 1; k <= N; k++) begin
                cand = mode_i ? (k - 1) : ((m_last + k) % N);
                if (win < 0 && ((m_req_r >> cand) & 1) == 1) win = cand;
            end
            m_owner = win; m_idx = win; m_hold = 0;
        end
        m_req_r = nreq;
    endtask

    task automatic check_all();
        check_eq("gnt_o",      gnt_o,      (m_owner >= 0) ? (1 << m_owner) : 0);
        check_eq("gnt_vld_o",  gnt_vld_o,  (m_owner >= 0) ? 1 : 0);
        check_eq("gnt_idx_o",  gnt_idx_o,  m_idx);
        check_eq("last_idx_o", last_idx_o, m_last);
        check_eq("timeout_o",  timeout_o,  m_to);
        check_eq("busy_o",     busy_o,     (m_owner >= 0 || m_cool != 0) ? 1 : 0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic go_idle();
        int n;
        req_i = '0; done_i = 1'b0;
        tick(); tick();
        n = 0;
        while (busy_o && n < 20) begin tick(); n++; end
        check_eq("go_idle", busy_o, 0);
    endtask

    initial begin
        int prev_vld, run, gap, ngr, pulses, n;
        rst_n = 1'b0; wr_allow_i = 1'b1; mode_i = 1'b0; req_i = '0; done_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_last_idx", last_idx_o, N - 1);
        check_all();
        rst_n = 1'b1;

        // Round-robin, all requesting, done 3 cycles into each grant.
        req_i = 4'b1111;
        prev_vld = 0; run = 0; gap = 0; ngr = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (gnt_vld_o && prev_vld == 0) begin
                if (ngr < 5) check_eq("rr_seq", gnt_idx_o, ngr % 4);
                if (ngr > 0 && ngr < 5) check_eq("rr_gap", gap, 2);
                ngr++; run = 0;
            end
            if (gnt_vld_o) run++;
            else if (prev_vld != 0) begin
                if (ngr <= 5) check_eq("rr_run", run, 4);
                gap = 0;
            end
            if (!gnt_vld_o) gap++;
            prev_vld = gnt_vld_o ? 1 : 0;
            done_i = (m_owner >= 0 && m_hold == 3);
        end
        check_eq("rr_grants", (ngr >= 5) ? 1 : 0, 1);

        // Fixed priority with 1010: index 1 always wins.
        go_idle();
        mode_i = 1'b1; req_i = 4'b1010; prev_vld = 0; ngr = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (gnt_vld_o && prev_vld == 0) begin
                check_eq("fixed_idx", gnt_idx_o, 1);
                ngr++;
            end
            prev_vld = gnt_vld_o ? 1 : 0;
            done_i = (m_owner >= 0 && m_hold == 1);
        end
        check_eq("fixed_grants", (ngr >= 3) ? 1 : 0, 1);

        // Watchdog: single requester never finishes.
        mode_i = 1'b0;
        go_idle();
        req_i = 4'b0100; prev_vld = 0; run = 0; ngr = 0; pulses = 0;
        for (int c = 0; c < 25; c++) begin
            tick();
            if (gnt_vld_o && prev_vld == 0) begin
                check_eq("wd_idx", gnt_idx_o, 2);
                ngr++; run = 0;
            end
            if (gnt_vld_o) run++;
            else if (prev_vld != 0 && ngr == 1) check_eq("wd_run", run, MH);
            if (timeout_o) pulses++;
            prev_vld = gnt_vld_o ? 1 : 0;
        end
        check_eq("wd_pulses", pulses, 2);

        // Withdrawal of the owner's request.
        go_idle();
        req_i = 4'b0010; n = 0;
        while (!gnt_vld_o && n < 10) begin tick(); n++; end
        check_eq("wdr_granted", gnt_o, 4'b0010);
        req_i = '0;
        tick();
        check_eq("wdr_still", gnt_vld_o, 1);
        tick();
        check_eq("wdr_drop", gnt_o, 0);
        check_eq("wdr_no_to", timeout_o, 0);
        tick();
        check_eq("wdr_last", last_idx_o, 1);

        // wr_allow_i gating.
        go_idle();
        wr_allow_i = 1'b0; req_i = 4'b0001;
        repeat (5) tick();
        check_eq("allow_block", gnt_o, 0);
        wr_allow_i = 1'b1;
        tick();
        check_eq("allow_grant", gnt_o, 4'b0001);
        wr_allow_i = 1'b0;
        repeat (3) tick();
        check_eq("allow_hold", gnt_o, 4'b0001);
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
        check_eq("allow_done", gnt_vld_o, 0);
        wr_allow_i = 1'b1;

        // done_i coincident with watchdog expiry: no timeout pulse.
        go_idle();
        req_i = 4'b0100; pulses = 0; ngr = 0; prev_vld = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (timeout_o) pulses++;
            if (gnt_vld_o && prev_vld == 0) ngr++;
            prev_vld = gnt_vld_o ? 1 : 0;
            done_i = (m_owner >= 0 && m_hold == MH - 1);
        end
        check_eq("coinc_pulses", pulses, 0);
        check_eq("coinc_grants", (ngr >= 1) ? 1 : 0, 1);

        // Async reset in the middle of a grant.
        done_i = 1'b0; n = 0;
        while (!(m_owner >= 0 && m_hold >= 4) && n < 20) begin tick(); n++; end
        check_eq("mid_granted", gnt_vld_o, 1);
        rst_n = 1'b0;
        #1;
        check_eq("arst_gnt",  gnt_o, 0);
        check_eq("arst_vld",  gnt_vld_o, 0);
        check_eq("arst_busy", busy_o, 0);
        check_eq("arst_last", last_idx_o, N - 1);
        check_eq("arst_idx",  gnt_idx_o, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_eq("arst_to", timeout_o, 0);
        rst_n = 1'b1; req_i = 4'b1111;
        tick();
        tick();
        check_eq("post_rst_idx", gnt_o, 4'b0001);

        // Random traffic.
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(9) == 0) req_i[b] = ~req_i[b];
            done_i     = ($urandom_range(5) == 0);
            wr_allow_i = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) mode_i = ~mode_i;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
